hilo_acc_unit: RTL and testbench
================================

// Module: hilo_acc_unit
// PURPOSE
//  Parametrised HI/LO special-register unit for the EX/MEM/WB pipeline. It holds the
//  2*DW-bit {hi,lo} pair and supports direct per-half writes plus MADD/MSUB-style
//  accumulate/subtract. It tracks outstanding multi-cycle mul/div ops and raises a read
//  stall until they retire. Sits beside the regfile and feeds the MFHI/MFLO read path.
// PARAMETERS
//  DW        32  width of each of hi/lo
//  PEND_MAX  3   max outstanding multi-cycle ops; CW = $clog2(PEND_MAX+1)
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    synchronous reset, active-high
//  wr_valid     in   1    commit a write this cycle
//  wr_mode      in   2    00 WRITE, 01 ADD, 10 SUB, 11 reserved (no-op)
//  wr_hi_en     in   1    WRITE mode only: update hi
//  wr_lo_en     in   1    WRITE mode only: update lo
//  wr_hi        in   DW   write data / addend upper half
//  wr_lo        in   DW   write data / addend lower half
//  wr_pend_done in   1    this write retires one outstanding op
//  pend_issue   in   1    a multi-cycle op was issued (count +1)
//  flush        in   1    pipeline flush: pending count cleared
//  rd_req       in   1    consumer wants hi_o/lo_o this cycle
//  rd_stall     out  1    consumer must hold (values not yet valid)
//  hi_o         out  DW   hi read data
//  lo_o         out  DW   lo read data
//  busy         out  1    pending count != 0
//  pend_err     out  1    1-cycle pulse: issue at PEND_MAX or done at 0 (ignored)
// BEHAVIOUR
//  - Reset: hi, lo, pend count = 0; hi_o = lo_o = 0; busy = rd_stall = pend_err = 0.
//    Reset mid-operation drops all pending ops and writes in that cycle.
//  - WRITE: the enabled halves take wr_hi/wr_lo at the next edge; disabled halves hold.
//  - ADD/SUB: {hi,lo} <= {hi,lo} +/- {wr_hi,wr_lo} modulo 2^(2*DW). Carry/borrow
//    propagates lo->hi. Both halves are written and the enables are ignored.
//  - Mode 11 or wr_valid=0: no register change; wr_pend_done is still honoured.
//  - Register write latency 1: the new value is in hi/lo after the edge.
//  - Pending count, next value priority: flush -> 0; else +issue -done.
//    issue & done together -> unchanged. issue at PEND_MAX or done at 0 -> that term is
//    ignored and pend_err pulses next cycle. flush does not block a same-cycle wr_valid
//    commit. Count saturates and never wraps.
//  - busy = (count != 0), registered view.
//  - rd_stall is combinational. It is never asserted when rd_req = 0.
//  - hi_o/lo_o present the read value every cycle regardless of rd_req.
// CONFIGURATION
//  HILO_BYPASS_EN defined:
//   - hi_o/lo_o = next-state {hi,lo}: same-cycle WRITE/ADD/SUB result, per-half
//     enables respected.
//   - rd_stall = rd_req & (count != 0) & !(count == 1 & wr_valid & wr_pend_done & !pend_issue).
//     The retiring write unblocks the reader in the same cycle.
//  HILO_BYPASS_EN undefined:
//   - hi_o/lo_o = registered hi/lo.
//   - rd_stall = rd_req & ((count != 0) | wr_valid). A same-cycle write stalls the reader
//     one cycle.
// TESTING
//  1 rst=1 2 cycles with wr_valid=1 -> hi_o=lo_o=0, busy=0, pend_err=0 after release.
//  2 WRITE hi_en only: wr_hi=0xDEADBEEF, lo preloaded 0x1 -> next cycle hi=0xDEADBEEF,
//    lo=0x1.
//  3 ADD {0x0,0xFFFFFFFF} + {0x0,0x1} -> {0x1,0x0}. SUB {0,0} - {0,1} ->
//    {0xFFFFFFFF,0xFFFFFFFF}.
//  4 pend_issue x3 then 4th issue -> count stays 3 and pend_err pulses once.
//    rd_req -> rd_stall=1 until the 3rd wr_pend_done.
//  5 Bypass: count=1, rd_req + wr_valid(WRITE 0x5/0x7) + done in the same cycle.
//    EN: rd_stall=0, hi_o=0x5, lo_o=0x7. non-EN: rd_stall=1, values appear next cycle.
//  6 flush with pend_issue and a WRITE in the same cycle -> count=0, busy=0 next cycle,
//    write committed.

Source files
------------

// File: rtl/hilo_acc_unit.sv
// hilo_acc_unit: HI/LO special-register pair with per-half writes, 2*DW-bit
// accumulate/subtract, and tracking of outstanding multi-cycle mul/div ops
// that stalls readers until those ops retire.
//
// Build option: define HILO_BYPASS_EN to forward the same-cycle write result
// onto hi_o/lo_o and let a retiring write release the reader in that cycle.
// With the macro undefined, hi_o/lo_o show the registered pair and any
// same-cycle write stalls the reader for one cycle.
//
// Handshake: rd_req is a request-only signal. The consumer samples hi_o/lo_o
// in a cycle where rd_req=1 and rd_stall=0. While rd_stall=1 the consumer
// holds rd_req asserted and retries. rd_stall is never 1 while rd_req=0.
module hilo_acc_unit #(
  parameter int DW       = 32,
  parameter int PEND_MAX = 3,
  parameter int CW       = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [1:0]    wr_mode,
  input  logic          wr_hi_en,
  input  logic          wr_lo_en,
  input  logic [DW-1:0] wr_hi,
  input  logic [DW-1:0] wr_lo,
  input  logic          wr_pend_done,
  input  logic          pend_issue,
  input  logic          flush,
  input  logic          rd_req,
  output logic          rd_stall,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          busy,
  output logic          pend_err
);

  localparam logic [1:0]    MODE_WRITE = 2'b00;
  localparam logic [1:0]    MODE_ADD   = 2'b01;
  localparam logic [1:0]    MODE_SUB   = 2'b10;
  localparam logic [CW-1:0] CNT_MAX    = CW'(PEND_MAX);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [2*DW-1:0] pair_cur;
  logic [2*DW-1:0] pair_arg;
  logic [2*DW-1:0] pair_sum;
  logic [2*DW-1:0] pair_dif;

  // Full-width add/subtract so carry and borrow cross from lo into hi.
  always_comb begin
    pair_cur = {hi_q, lo_q};
    pair_arg = {wr_hi, wr_lo};
    pair_sum = pair_cur + pair_arg;
    pair_dif = pair_cur - pair_arg;
  end

  // Next {hi,lo}: a reset cycle drops the write; mode 11 changes nothing.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (rst) begin
      hi_d = '0;
      lo_d = '0;
    end else if (wr_valid) begin
      case (wr_mode)
        MODE_WRITE: begin
          if (wr_hi_en) hi_d = wr_hi;
          if (wr_lo_en) lo_d = wr_lo;
        end
        MODE_ADD: {hi_d, lo_d} = pair_sum;
        MODE_SUB: {hi_d, lo_d} = pair_dif;
        default: ;
      endcase
    end
  end

  // Next pending count: flush wins; issue and done cancel; an out-of-range
  // term is dropped and flagged so the count saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else if (pend_issue && wr_pend_done) begin
      cnt_d = cnt_q;
    end else if (pend_issue) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end else if (wr_pend_done) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_ONE;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Read path and stall generation.
  always_comb begin
    busy     = (cnt_q != '0);
    pend_err = err_q;
`ifdef HILO_BYPASS_EN
    hi_o     = hi_d;
    lo_o     = lo_d;
    rd_stall = rd_req && !rst && (cnt_q != '0) &&
               !((cnt_q == CNT_ONE) && wr_valid && wr_pend_done && !pend_issue);
`else
    hi_o     = hi_q;
    lo_o     = lo_q;
    rd_stall = rd_req && !rst && ((cnt_q != '0) || wr_valid);
`endif
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit (DW=32, PEND_MAX=3). Compile with
// HILO_BYPASS_EN defined to check the bypass build of the unit.
module tb_hilo_acc_unit;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic [1:0]    wr_mode;
  logic          wr_hi_en;
  logic          wr_lo_en;
  logic [DW-1:0] wr_hi;
  logic [DW-1:0] wr_lo;
  logic          wr_pend_done;
  logic          pend_issue;
  logic          flush;
  logic          rd_req;
  logic          rd_stall;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          busy;
  logic          pend_err;

  int checks = 0;
  int errors = 0;

  hilo_acc_unit #(.DW(DW), .PEND_MAX(3)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_mode(wr_mode),
    .wr_hi_en(wr_hi_en), .wr_lo_en(wr_lo_en), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wr_pend_done(wr_pend_done), .pend_issue(pend_issue), .flush(flush),
    .rd_req(rd_req), .rd_stall(rd_stall), .hi_o(hi_o), .lo_o(lo_o),
    .busy(busy), .pend_err(pend_err)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then step off it so inputs and samples are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_mode = 2'b00; wr_hi_en = 1'b0; wr_lo_en = 1'b0;
    wr_hi = '0; wr_lo = '0; wr_pend_done = 1'b0; pend_issue = 1'b0;
    flush = 1'b0; rd_req = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] mode, input logic hen, input logic len,
                          input logic [DW-1:0] h, input logic [DW-1:0] l);
    wr_valid = 1'b1; wr_mode = mode; wr_hi_en = hen; wr_lo_en = len;
    wr_hi = h; wr_lo = l;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    drive_wr(2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pend_issue = 1'b1;
    step();
    step();
    idle();
    rst = 1'b0;
    #1;
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", pend_err); end
    rd_req = 1'b1;
    #1;
    checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", rd_stall); end
    idle();
  endtask

  task automatic test_write();
    drive_wr(2'b00, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_0001);
    step();
    drive_wr(2'b00, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    step();
    idle();
    #1;
    checks++; if (hi_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_hi got %h exp deadbeef", hi_o); end
    checks++; if (lo_o !== 32'h0000_0001) begin errors++; $display("FAIL write_lo got %h exp 00000001", lo_o); end
  endtask

  task automatic test_addsub();
    drive_wr(2'b00, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    step();
    drive_wr(2'b01, 1'b0, 1'b0, 32'h0, 32'h1);
    step();
    idle();
    #1;
    checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL add_carry_hi got %h exp 00000001", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL add_carry_lo got %h exp 0", lo_o); end
    // ADD without carry into a non-zero hi: {1,0} + {2,5} = {3,5}
    drive_wr(2'b01, 1'b1, 1'b0, 32'h2, 32'h5);
    step();
    idle();
    #1;
    checks++; if ({hi_o, lo_o} !== {32'h3, 32'h5}) begin errors++; $display("FAIL add_plain got %h_%h exp 00000003_00000005", hi_o, lo_o); end
    drive_wr(2'b00, 1'b1, 1'b1, 32'h0, 32'h0);
    step();
    drive_wr(2'b10, 1'b0, 1'b0, 32'h0, 32'h1);
    step();
    idle();
    #1;
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow_hi got %h exp ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_borrow_lo got %h exp ffffffff", lo_o); end
    drive_wr(2'b11, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    idle();
    #1;
    checks++; if ({hi_o, lo_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin errors++; $display("FAIL mode11_hold got %h_%h exp ffffffff_ffffffff", hi_o, lo_o); end
  endtask

  task automatic test_pending();
    pend_issue = 1'b1;
    step();
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_busy3 got %b exp 1", busy); end
    checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL pend_err_early got %b exp 0", pend_err); end
    step();
    idle();
    checks++; if (pend_err !== 1'b1) begin errors++; $display("FAIL pend_err_over got %b exp 1", pend_err); end
    #1;
    checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL stall_no_req got %b exp 0", rd_stall); end
    step();
    checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL pend_err_oneshot got %b exp 0", pend_err); end
    rd_req = 1'b1;
    #1;
    checks++; if (rd_stall !== 1'b1) begin errors++; $display("FAIL stall_cnt3 got %b exp 1", rd_stall); end
    // Retire with mode-11 writes so the register pair is untouched.
    for (int i = 0; i < 3; i++) begin
      drive_wr(2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
      wr_pend_done = 1'b1;
      step();
      wr_valid = 1'b0;
      wr_pend_done = 1'b0;
      #1;
      if (i < 2) begin
        checks++; if (rd_stall !== 1'b1) begin errors++; $display("FAIL stall_after_done%0d got %b exp 1", i + 1, rd_stall); end
      end else begin
        checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL stall_released got %b exp 0", rd_stall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_released got %b exp 0", busy); end
      end
    end
    // Done at zero is ignored and flagged.
    idle();
    wr_pend_done = 1'b1;
    step();
    idle();
    checks++; if (pend_err !== 1'b1) begin errors++; $display("FAIL pend_err_under got %b exp 1", pend_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_under got %b exp 0", busy); end
  endtask

  task automatic test_bypass();
    pend_issue = 1'b1;
    step();
    idle();
    rd_req = 1'b1;
    drive_wr(2'b00, 1'b1, 1'b1, 32'h5, 32'h7);
    wr_pend_done = 1'b1;
    #1;
`ifdef HILO_BYPASS_EN
    checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL byp_stall got %b exp 0", rd_stall); end
    checks++; if ({hi_o, lo_o} !== {32'h5, 32'h7}) begin errors++; $display("FAIL byp_data got %h_%h exp 00000005_00000007", hi_o, lo_o); end
`else
    checks++; if (rd_stall !== 1'b1) begin errors++; $display("FAIL nobyp_stall got %b exp 1", rd_stall); end
    checks++; if ({hi_o, lo_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin errors++; $display("FAIL nobyp_old got %h_%h exp ffffffff_ffffffff", hi_o, lo_o); end
`endif
    step();
    idle();
    rd_req = 1'b1;
    #1;
    checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL byp_next_stall got %b exp 0", rd_stall); end
    checks++; if ({hi_o, lo_o} !== {32'h5, 32'h7}) begin errors++; $display("FAIL byp_next_data got %h_%h exp 00000005_00000007", hi_o, lo_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL byp_next_busy got %b exp 0", busy); end
    idle();
  endtask

  task automatic test_flush();
    pend_issue = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b exp 1", busy); end
    flush = 1'b1;
    drive_wr(2'b00, 1'b1, 1'b1, 32'hA, 32'hB);
    step();
    idle();
    rd_req = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    checks++; if (pend_err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", pend_err); end
    checks++; if ({hi_o, lo_o} !== {32'hA, 32'hB}) begin errors++; $display("FAIL flush_write got %h_%h exp 0000000a_0000000b", hi_o, lo_o); end
    checks++; if (rd_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", rd_stall); end
    idle();
  endtask

  task automatic test_back_to_back();
    // Consecutive ADDs accumulate: {A,B} + {0,FFFFFFF5} = {B,0}; + {1,1} = {C,1}
    drive_wr(2'b01, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF5);
    step();
    drive_wr(2'b01, 1'b0, 1'b0, 32'h1, 32'h1);
    step();
    idle();
    #1;
    checks++; if ({hi_o, lo_o} !== {32'hC, 32'h1}) begin errors++; $display("FAIL b2b_add got %h_%h exp 0000000c_00000001", hi_o, lo_o); end
  endtask

  // Test sequence and summary.
  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_write();
    test_addsub();
    test_pending();
    test_bypass();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
